// File: rtl/c3lib_sync_deglitch_edge.sv
// c3lib_sync_deglitch_edge: deglitch filter on a synchronized level with edge pulses and saturating event count
module c3lib_sync_deglitch_edge #(
  parameter logic RESET_VAL     = 1'b1,
  parameter int   FILTER_CYCLES = 4,
  parameter int   CNT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_in,
  input  logic                 clr_cnt,
  output logic                 data_out,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [CNT_WIDTH-1:0] evt_cnt,
  output logic                 busy
);
  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam logic [FW-1:0] FCNT_LAST = FW'(FILTER_CYCLES - 1);
  typedef enum logic {ST_STABLE, ST_QUALIFY} state_t;
  state_t               r_state, w_state_nxt;
  logic [FW-1:0]        r_fcnt, w_fcnt_nxt;
  logic                 r_data_out, r_rise, r_fall;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic                 w_diff, w_commit;
  always_comb begin
    w_diff      = data_in != r_data_out;
    w_commit    = 1'b0;
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    if (r_state == ST_STABLE) begin
      if (w_diff && FILTER_CYCLES == 1) begin
        w_commit = 1'b1;
      end else if (w_diff) begin
        w_fcnt_nxt  = FW'(1);
        w_state_nxt = ST_QUALIFY;
      end
    end else begin
      if (!w_diff || r_fcnt == FCNT_LAST) begin
        w_commit    = w_diff;
        w_fcnt_nxt  = '0;
        w_state_nxt = ST_STABLE;
      end else begin
        w_fcnt_nxt = r_fcnt + FW'(1);
      end
    end
    // a commit coinciding with a clear restarts the count at 1 so the event is kept
    w_cnt_nxt = w_commit ? (clr_cnt ? CNT_WIDTH'(1) : (&r_cnt ? r_cnt : r_cnt + CNT_WIDTH'(1)))
                         : (clr_cnt ? '0 : r_cnt);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_STABLE;
      r_fcnt     <= '0;
      r_data_out <= RESET_VAL;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fcnt     <= w_fcnt_nxt;
      r_data_out <= w_commit ? data_in : r_data_out;
      r_rise     <= w_commit & data_in;
      r_fall     <= w_commit & ~data_in;
      r_cnt      <= w_cnt_nxt;
    end
  end
  assign data_out   = r_data_out;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign evt_cnt    = r_cnt;
  assign busy       = r_state == ST_QUALIFY;
endmodule

// File: tb/tb_c3lib_sync_deglitch_edge.sv
// tb_c3lib_sync_deglitch_edge: directed checks of filtering, pulses, counting and reset behavior
module tb_c3lib_sync_deglitch_edge;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail  = 0;
  logic       rst_a = 1'b1, din_a = 1'b1, clr_a = 1'b0;
  logic       dout_a, rise_a, fall_a, busy_a;
  logic [7:0] cnt_a;
  logic       rst_b = 1'b1, din_b = 1'b1, clr_b = 1'b0;
  logic       dout_b, rise_b, fall_b, busy_b;
  logic [1:0] cnt_b;
  logic       rst_c = 1'b1, din_c = 1'b1, clr_c = 1'b0;
  logic       dout_c, rise_c, fall_c, busy_c;
  logic [7:0] cnt_c;
  c3lib_sync_deglitch_edge #(.RESET_VAL(1'b1), .FILTER_CYCLES(4), .CNT_WIDTH(8)) u_a (
    .clk(clk), .rst(rst_a), .data_in(din_a), .clr_cnt(clr_a), .data_out(dout_a),
    .rise_pulse(rise_a), .fall_pulse(fall_a), .evt_cnt(cnt_a), .busy(busy_a));
  c3lib_sync_deglitch_edge #(.RESET_VAL(1'b1), .FILTER_CYCLES(4), .CNT_WIDTH(2)) u_b (
    .clk(clk), .rst(rst_b), .data_in(din_b), .clr_cnt(clr_b), .data_out(dout_b),
    .rise_pulse(rise_b), .fall_pulse(fall_b), .evt_cnt(cnt_b), .busy(busy_b));
  c3lib_sync_deglitch_edge #(.RESET_VAL(1'b1), .FILTER_CYCLES(1), .CNT_WIDTH(8)) u_c (
    .clk(clk), .rst(rst_c), .data_in(din_c), .clr_cnt(clr_c), .data_out(dout_c),
    .rise_pulse(rise_c), .fall_pulse(fall_c), .evt_cnt(cnt_c), .busy(busy_c));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    #1;
    // reset hold and release
    tick(1);
    chk("a_rst_dout", dout_a, 1);
    chk("a_rst_busy", busy_a, 0);
    tick(2);
    rst_a = 1'b0;
    tick(1);
    chk("a_rel_dout", dout_a, 1);
    chk("a_rel_pulses", {rise_a, fall_a}, 0);
    chk("a_rel_cnt", cnt_a, 0);
    chk("a_rel_busy", busy_a, 0);
    // qualified fall
    din_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("a_fall_busy", busy_a, 1);
      chk("a_fall_hold", dout_a, 1);
      chk("a_fall_nopulse", fall_a, 0);
    end
    tick(1);
    chk("a_fall_dout", dout_a, 0);
    chk("a_fall_pulse", {rise_a, fall_a}, 2'b01);
    chk("a_fall_cnt", cnt_a, 1);
    chk("a_fall_busy_end", busy_a, 0);
    tick(1);
    chk("a_fall_pulse_1cyc", fall_a, 0);
    // back to high, then a 3-cycle low glitch
    din_a = 1'b1;
    tick(4);
    chk("a_rise_dout", dout_a, 1);
    chk("a_rise_pulse", {rise_a, fall_a}, 2'b10);
    chk("a_rise_cnt", cnt_a, 2);
    tick(1);
    din_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("a_gl_busy", busy_a, 1);
      chk("a_gl_dout", dout_a, 1);
    end
    din_a = 1'b1;
    tick(1);
    chk("a_gl_busy_end", busy_a, 0);
    chk("a_gl_dout_end", dout_a, 1);
    chk("a_gl_nopulse", {rise_a, fall_a}, 0);
    chk("a_gl_cnt", cnt_a, 2);
    // reset mid-qualification
    din_a = 1'b0;
    tick(2);
    chk("a_mid_busy", busy_a, 1);
    rst_a = 1'b1;
    tick(1);
    chk("a_mid_dout", dout_a, 1);
    chk("a_mid_nofall", fall_a, 0);
    chk("a_mid_busy_rst", busy_a, 0);
    chk("a_mid_cnt", cnt_a, 0);
    rst_a = 1'b0;
    tick(3);
    chk("a_mid_wait_dout", dout_a, 1);
    chk("a_mid_wait_fall", fall_a, 0);
    tick(1);
    chk("a_mid_commit_dout", dout_a, 0);
    chk("a_mid_commit_fall", fall_a, 1);
    chk("a_mid_commit_cnt", cnt_a, 1);
    // saturation and clear with a 2-bit counter
    rst_b = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      din_b = ~din_b;
      tick(4);
      chk("b_tog_dout", dout_b, din_b);
      chk("b_tog_cnt", cnt_b, (i < 3) ? i : 3);
      tick(1);
    end
    din_b = 1'b1;
    tick(3);
    clr_b = 1'b1;
    tick(1);
    clr_b = 1'b0;
    chk("b_clr_commit_cnt", cnt_b, 1);
    chk("b_clr_commit_rise", rise_b, 1);
    tick(1);
    clr_b = 1'b1;
    tick(1);
    clr_b = 1'b0;
    chk("b_clr_alone_cnt", cnt_b, 0);
    chk("b_clr_alone_dout", dout_b, 1);
    // FILTER_CYCLES=1 follows every cycle
    rst_c = 1'b0;
    tick(1);
    chk("c_idle_dout", dout_c, 1);
    for (int i = 0; i < 8; i++) begin
      din_c = ~din_c;
      tick(1);
      chk("c_trk_dout", dout_c, din_c);
      chk("c_trk_pulse", {rise_c, fall_c}, din_c ? 2'b10 : 2'b01);
      chk("c_trk_busy", busy_c, 0);
    end
    chk("c_trk_cnt", cnt_c, 8);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
